// File: rtl/uart_pkg.sv
// uart_pkg -- shared definitions for the UART frame serializer.
//
// Contents:
//   uart_frame_state_t   : state encoding of uart_frame_tx
//   UART_MAX_BYTES_LIMIT : largest payload length the serializer supports
//   uart_cnt_w()         : width of a byte counter able to hold 0..max_bytes
package uart_pkg;

  localparam int UART_MAX_BYTES_LIMIT = 32;

  typedef enum logic [2:0] {
    UFS_IDLE   = 3'd0,
    UFS_ISSUE  = 3'd1,
    UFS_GAP    = 3'd2,
    UFS_DRAIN  = 3'd3,
    UFS_FINISH = 3'd4
  } uart_frame_state_t;

  // Bits needed to represent the values 0..max_bytes inclusive.
  function automatic int uart_cnt_w(input int max_bytes);
    return $clog2(max_bytes + 1);
  endfunction

endpackage : uart_pkg

// File: rtl/uart_frame_tx.sv
// uart_frame_tx -- frame serializer feeding a byte-wide UART transmitter.
//
// Captures up to MAX_BYTES payload bytes on a start pulse and hands them to
// the UART one byte per tx_wr strobe. After each strobe it waits GAP_CYCLES
// cycles (transmitter busy-assert latency) and then for tx_busy to drop.
//
// Optional feature (compile-time macro UART_FRAME_CSUM_EN): when defined, an
// extra byte holding the XOR of all payload bytes is sent after the payload.
//
// Ports:
//   clk, rst_n        : clock, asynchronous active-low reset
//   start, abort      : frame request (honoured in IDLE only), synchronous abort
//   byte_cnt          : payload length 1..MAX_BYTES, sampled with start
//   msb_first         : 1 = highest-indexed byte goes out first
//   data_in           : payload, byte k at data_in[8k+7:8k]
//   tx_busy           : transmitter busy flag
//   tx_data, tx_wr    : byte to transmit and its one-cycle write strobe
//   busy, done, err   : frame in progress, end-of-frame pulse, bad-length pulse
module uart_frame_tx
  import uart_pkg::*;
#(
  parameter int MAX_BYTES  = 10,
  parameter int GAP_CYCLES = 5,
  parameter int CNT_W      = uart_cnt_w(MAX_BYTES)
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   start,
  input  logic                   abort,
  input  logic [CNT_W-1:0]       byte_cnt,
  input  logic                   msb_first,
  input  logic [8*MAX_BYTES-1:0] data_in,
  input  logic                   tx_busy,
  output logic [7:0]             tx_data,
  output logic                   tx_wr,
  output logic                   busy,
  output logic                   done,
  output logic                   err
);

  localparam int GAP_W    = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
  localparam int GAP_LAST = (GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0;

  uart_frame_state_t      state_q, state_d;
  logic [CNT_W-1:0]       idx_q, idx_d;
  logic [CNT_W-1:0]       n_q, n_d;
  logic                   msb_q, msb_d;
  logic [8*MAX_BYTES-1:0] data_q, data_d;
  logic [GAP_W-1:0]       gap_q, gap_d;
  logic [7:0]             tx_data_q, tx_data_d;
  logic                   tx_wr_q, tx_wr_d;
  logic                   busy_q, busy_d;
  logic                   done_q, done_d;
  logic                   err_q, err_d;
`ifdef UART_FRAME_CSUM_EN
  logic [7:0]             csum_q, csum_d;
`endif

  logic [CNT_W-1:0]       last_idx;
  logic [CNT_W-1:0]       pos;
  logic [7:0]             issue_byte;

  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    n_d       = n_q;
    msb_d     = msb_q;
    data_d    = data_q;
    gap_d     = gap_q;
    tx_data_d = tx_data_q;
    err_d     = 1'b0;
`ifdef UART_FRAME_CSUM_EN
    csum_d    = csum_q;
    last_idx  = n_q;                  // checksum occupies index n
`else
    last_idx  = n_q - CNT_W'(1);
`endif

    unique case (state_q)
      UFS_IDLE: begin
        if (start && !abort) begin
          if (byte_cnt != '0 && byte_cnt <= CNT_W'(MAX_BYTES)) begin
            n_d     = byte_cnt;
            msb_d   = msb_first;
            data_d  = data_in;
            idx_d   = '0;
`ifdef UART_FRAME_CSUM_EN
            csum_d  = 8'h00;
`endif
            state_d = UFS_ISSUE;
          end else begin
            err_d = 1'b1;
          end
        end
      end
      UFS_ISSUE: begin
        gap_d   = '0;
        state_d = (GAP_CYCLES == 0) ? UFS_DRAIN : UFS_GAP;
      end
      UFS_GAP: begin
        if (gap_q == GAP_W'(GAP_LAST)) state_d = UFS_DRAIN;
        else                           gap_d   = gap_q + GAP_W'(1);
      end
      UFS_DRAIN: begin
        if (!tx_busy) begin
          if (idx_q == last_idx) begin
            state_d = UFS_FINISH;
          end else begin
            idx_d   = idx_q + CNT_W'(1);
            state_d = UFS_ISSUE;
          end
        end
      end
      UFS_FINISH: state_d = UFS_IDLE;
      default:    state_d = UFS_IDLE;
    endcase

    if (abort) state_d = UFS_IDLE;

    // The byte is selected from the next-cycle view of the frame registers so
    // that the first byte can be registered onto tx_data at the start edge.
    pos = msb_d ? (n_d - CNT_W'(1) - idx_d) : idx_d;
    issue_byte = 8'h00;
    for (int b = 0; b < MAX_BYTES; b++) begin
      if (pos == CNT_W'(b)) issue_byte = data_d[8*b +: 8];
    end
`ifdef UART_FRAME_CSUM_EN
    if (idx_d == n_d) issue_byte = csum_q;
`endif

    if (state_d == UFS_ISSUE) begin
      tx_data_d = issue_byte;
`ifdef UART_FRAME_CSUM_EN
      if (idx_d != n_d) csum_d = csum_d ^ issue_byte;
`endif
    end

    // Status outputs are registered copies of the next state.
    tx_wr_d = (state_d == UFS_ISSUE);
    busy_d  = (state_d != UFS_IDLE);
    done_d  = (state_d == UFS_FINISH);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= UFS_IDLE;
      idx_q     <= '0;
      n_q       <= '0;
      msb_q     <= 1'b0;
      data_q    <= '0;
      gap_q     <= '0;
      tx_data_q <= 8'h00;
      tx_wr_q   <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
`ifdef UART_FRAME_CSUM_EN
      csum_q    <= 8'h00;
`endif
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      n_q       <= n_d;
      msb_q     <= msb_d;
      data_q    <= data_d;
      gap_q     <= gap_d;
      tx_data_q <= tx_data_d;
      tx_wr_q   <= tx_wr_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      err_q     <= err_d;
`ifdef UART_FRAME_CSUM_EN
      csum_q    <= csum_d;
`endif
    end
  end

  assign tx_data = tx_data_q;
  assign tx_wr   = tx_wr_q;
  assign busy    = busy_q;
  assign done    = done_q;
  assign err     = err_q;

endmodule : uart_frame_tx

// File: tb/tb_uart_frame_tx.sv
// tb_uart_frame_tx -- self-checking bench for uart_frame_tx.
// Main instance: MAX_BYTES=10, GAP_CYCLES=5 with a modelled UART whose busy
// flag stays high for a programmable number of cycles after each tx_wr.
// Second instance: GAP_CYCLES=0 with tx_busy tied low.
// Honours UART_FRAME_CSUM_EN (checksum byte appended to expected frames).
`timescale 1ns/1ps
module tb_uart_frame_tx;
  localparam int MB   = 10;
  localparam int G    = 5;
  localparam int CW   = $clog2(MB + 1);
  localparam int HIST = 65536;
`ifdef UART_FRAME_CSUM_EN
  localparam bit CSUM = 1'b1;
`else
  localparam bit CSUM = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // main instance
  logic            start = 1'b0, abort = 1'b0, msb_first = 1'b0, tx_busy = 1'b0;
  logic [CW-1:0]   byte_cnt = '0;
  logic [8*MB-1:0] data_in = '0;
  logic [7:0]      tx_data;
  logic            tx_wr, busy, done, err;

  uart_frame_tx #(.MAX_BYTES(MB), .GAP_CYCLES(G)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort), .byte_cnt(byte_cnt),
    .msb_first(msb_first), .data_in(data_in), .tx_busy(tx_busy),
    .tx_data(tx_data), .tx_wr(tx_wr), .busy(busy), .done(done), .err(err));

  // zero-gap instance, transmitter never busy
  logic            start0 = 1'b0, abort0 = 1'b0, msb0 = 1'b0, tx_busy0 = 1'b0;
  logic [CW-1:0]   cnt0 = '0;
  logic [8*MB-1:0] data0 = '0;
  logic [7:0]      tx_data0;
  logic            tx_wr0, busy0, done0, err0;

  uart_frame_tx #(.MAX_BYTES(MB), .GAP_CYCLES(0)) dut0 (
    .clk(clk), .rst_n(rst_n), .start(start0), .abort(abort0), .byte_cnt(cnt0),
    .msb_first(msb0), .data_in(data0), .tx_busy(tx_busy0),
    .tx_data(tx_data0), .tx_wr(tx_wr0), .busy(busy0), .done(done0), .err(err0));

  int errors = 0;
  int checks = 0;

  logic [7:0] wr_data[$];
  int         wr_cyc[$];
  int         done_cyc[$];
  logic [7:0] wr0_data[$];
  int         wr0_cyc[$];
  int         done0_cyc[$];
  logic [7:0] exp_q[$];
  bit         busy_hist[HIST];
  int         err_n = 0;
  int         busy_len = 0;
  int         busy_left = 0;

  // Observer plus behavioural UART: busy for busy_len cycles after each write.
  always @(negedge clk) begin
    if (tx_wr === 1'b1) begin
      wr_data.push_back(tx_data);
      wr_cyc.push_back(cyc);
    end
    if (done === 1'b1) done_cyc.push_back(cyc);
    if (err === 1'b1) err_n++;
    busy_hist[cyc % HIST] = (busy === 1'b1);
    if (!rst_n)              busy_left = 0;
    else if (tx_wr === 1'b1) busy_left = busy_len;
    else if (busy_left > 0)  busy_left--;
    tx_busy = (busy_left > 0);
    if (tx_wr0 === 1'b1) begin
      wr0_data.push_back(tx_data0);
      wr0_cyc.push_back(cyc);
    end
    if (done0 === 1'b1) done0_cyc.push_back(cyc);
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Expected byte stream from the byte-order rule, plus optional XOR byte.
  task automatic build_exp(input int n, input bit msb, input logic [8*MB-1:0] d);
    logic [7:0] x;
    logic [7:0] b;
    exp_q.delete();
    x = 8'h00;
    for (int k = 0; k < n; k++) begin
      b = msb ? d[8*(n-1-k) +: 8] : d[8*k +: 8];
      exp_q.push_back(b);
      x ^= b;
    end
    if (CSUM) exp_q.push_back(x);
  endtask

  // Write spacing: GAP_CYCLES+2 at least, longer when the UART is still busy.
  function automatic int exp_space(input int blen);
    return ((G + 2) > (blen + 1)) ? (G + 2) : (blen + 1);
  endfunction

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic run_frame(input string tag, input int n, input bit msb,
                           input logic [8*MB-1:0] d, input int blen);
    int t0, sp, e0, lows, nc;
    wr_data.delete(); wr_cyc.delete(); done_cyc.delete();
    busy_len = blen;
    e0 = err_n;
    tick();
    start = 1'b1; byte_cnt = CW'(n); msb_first = msb; data_in = d; t0 = cyc;
    tick();
    start = 1'b0; data_in = ~d; msb_first = ~msb; byte_cnt = CW'(MB);
    tick(); tick();
    start = 1'b1;                      // mid-frame request, must be ignored
    tick();
    start = 1'b0;
    for (int i = 0; i < 3000 && done_cyc.size() == 0; i++) tick();
    tick(); tick();
    build_exp(n, msb, d);
    sp = exp_space(blen);
    chk({tag, " done_count"}, done_cyc.size(), 1);
    chk({tag, " write_count"}, wr_data.size(), exp_q.size());
    nc = (wr_data.size() < exp_q.size()) ? wr_data.size() : exp_q.size();
    for (int k = 0; k < nc; k++)
      chk($sformatf("%s byte%0d", tag, k), wr_data[k], exp_q[k]);
    if (wr_cyc.size() > 0) chk({tag, " first_wr_cycle"}, wr_cyc[0], t0 + 1);
    for (int k = 1; k < wr_cyc.size(); k++)
      chk($sformatf("%s spacing%0d", tag, k), wr_cyc[k] - wr_cyc[k-1], sp);
    if (done_cyc.size() > 0 && wr_cyc.size() > 0) begin
      chk({tag, " done_delay"}, done_cyc[0] - wr_cyc[wr_cyc.size()-1], sp);
      lows = 0;
      for (int c = t0 + 1; c <= done_cyc[0]; c++) if (!busy_hist[c % HIST]) lows++;
      chk({tag, " busy_low_cycles"}, lows, 0);
      chk({tag, " busy_after_done"}, busy_hist[(done_cyc[0] + 1) % HIST], 0);
    end
    chk({tag, " no_err"}, err_n - e0, 0);
  endtask

  logic [8*MB-1:0] d;
  int e0, blen, n;
  bit msb;

  initial begin
    // reset state
    tick(); tick();
    chk("rst tx_data", tx_data, 8'h00);
    chk("rst tx_wr", tx_wr, 0);
    chk("rst busy", busy, 0);
    chk("rst done", done, 0);
    chk("rst err", err, 0);
    rst_n = 1'b1;
    tick(); tick();
    chk("idle busy", busy, 0);

    // directed byte-order frames
    d = '0; d[23:0] = 24'hA1B2C3;
    run_frame("msb3", 3, 1'b1, d, 20);
    run_frame("lsb3", 3, 1'b0, d, 20);
    d = '0; d[23:0] = 24'h563412;
    run_frame("csum3", 3, 1'b0, d, 0);
`ifdef UART_FRAME_CSUM_EN
    if (wr_data.size() > 3) chk("csum byte", wr_data[3], 8'h70);
    else chk("csum present", wr_data.size(), 4);
`endif

    // illegal lengths
    e0 = err_n; wr_data.delete();
    tick(); start = 1'b1; byte_cnt = CW'(0);
    tick(); start = 1'b0;
    tick(); tick();
    chk("err len0", err_n - e0, 1);
    tick(); start = 1'b1; byte_cnt = CW'(MB + 1);
    tick(); start = 1'b0;
    tick(); tick();
    chk("err len11", err_n - e0, 2);
    chk("err no writes", wr_data.size(), 0);
    chk("err busy", busy, 0);

    // abort and start together in IDLE: abort wins
    e0 = err_n;
    tick(); start = 1'b1; abort = 1'b1; byte_cnt = CW'(3);
    tick(); start = 1'b0; abort = 1'b0;
    tick(); tick(); tick();
    chk("abort+start writes", wr_data.size(), 0);
    chk("abort+start busy", busy, 0);
    chk("abort+start err", err_n - e0, 0);

    // abort in the GAP after the second byte of a five-byte frame
    for (int k = 0; k < MB; k++) d[8*k +: 8] = 8'($urandom_range(0, 255));
    wr_data.delete(); done_cyc.delete(); busy_len = 20;
    tick(); start = 1'b1; byte_cnt = CW'(5); msb_first = 1'b0; data_in = d;
    tick(); start = 1'b0;
    for (int i = 0; i < 200 && wr_data.size() < 2; i++) tick();
    tick(); abort = 1'b1;
    tick(); abort = 1'b0;
    chk("abort tx_wr", tx_wr, 0);
    chk("abort busy", busy, 0);
    chk("abort tx_data hold", tx_data, d[15:8]);
    tick();
    chk("abort writes", wr_data.size(), 2);
    chk("abort no done", done_cyc.size(), 0);
    for (int k = 0; k < MB; k++) d[8*k +: 8] = 8'($urandom_range(0, 255));
    run_frame("after_abort", 2, 1'b1, d, 4);

    // reset in mid-frame
    wr_data.delete(); done_cyc.delete(); busy_len = 0;
    tick(); start = 1'b1; byte_cnt = CW'(5); msb_first = 1'b1; data_in = d;
    tick(); start = 1'b0;
    for (int i = 0; i < 200 && wr_data.size() < 1; i++) tick();
    tick(); tick();
    rst_n = 1'b0;
    #1;
    chk("midrst tx_data", tx_data, 8'h00);
    chk("midrst busy", busy, 0);
    chk("midrst tx_wr", tx_wr, 0);
    tick(); rst_n = 1'b1;
    for (int i = 0; i < 40; i++) tick();
    chk("midrst writes", wr_data.size(), 1);
    chk("midrst no done", done_cyc.size(), 0);

    // length boundaries and randomized frames
    for (int k = 0; k < MB; k++) d[8*k +: 8] = 8'($urandom_range(0, 255));
    run_frame("max10", MB, 1'b1, d, 0);
    run_frame("one", 1, 1'b0, d, 3);
    for (int r = 0; r < 6; r++) begin
      for (int k = 0; k < MB; k++) d[8*k +: 8] = 8'($urandom_range(0, 255));
      n    = $urandom_range(1, MB);
      msb  = 1'($urandom_range(0, 1));
      blen = $urandom_range(0, 25);
      run_frame($sformatf("rand%0d", r), n, msb, d, blen);
    end

    // zero-gap instance: full-length frame, one write every two cycles
    for (int k = 0; k < MB; k++) d[8*k +: 8] = 8'($urandom_range(0, 255));
    wr0_data.delete(); wr0_cyc.delete(); done0_cyc.delete();
    tick(); start0 = 1'b1; cnt0 = CW'(MB); msb0 = 1'b1; data0 = d; e0 = cyc;
    tick(); start0 = 1'b0; data0 = '0;
    for (int i = 0; i < 300 && done0_cyc.size() == 0; i++) tick();
    tick();
    build_exp(MB, 1'b1, d);
    chk("gap0 done_count", done0_cyc.size(), 1);
    chk("gap0 write_count", wr0_data.size(), exp_q.size());
    for (int k = 0; k < wr0_data.size() && k < exp_q.size(); k++)
      chk($sformatf("gap0 byte%0d", k), wr0_data[k], exp_q[k]);
    if (wr0_cyc.size() > 0) chk("gap0 first_wr_cycle", wr0_cyc[0], e0 + 1);
    for (int k = 1; k < wr0_cyc.size(); k++)
      chk($sformatf("gap0 spacing%0d", k), wr0_cyc[k] - wr0_cyc[k-1], 2);
    if (done0_cyc.size() > 0 && wr0_cyc.size() > 0)
      chk("gap0 done_delay", done0_cyc[0] - wr0_cyc[wr0_cyc.size()-1], 2);
    chk("gap0 busy_after", busy0, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule : tb_uart_frame_tx
